demux_fifo: RTL and testbench

- Downstream stage of the 2:1 valid/data mux.
- Takes the mux's single 4-bit valid/data stream and splits it back into two lanes by strict alternation: first accepted word to lane 0, next to lane 1, and so on.
- Each lane is buffered in its own small synchronous FIFO, drained independently by consumer pop requests.
- There is no backpressure to upstream. Overflow drops the word and raises a sticky error.

---
 rtl/demux_fifo_pkg.sv | 23 ++
 rtl/demux_fifo_if.sv | 67 ++++++
 rtl/demux_fifo_sync_fifo.sv | 97 +++++++++
 rtl/demux_fifo.sv | 94 +++++++++
 tb/tb_demux_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_fifo_pkg.sv
// demux_fifo shared definitions: default sizes, lane indices, width helpers.
// Optional almost-full outputs are enabled with DEMUX_ALMOST_FULL_EN.
package demux_pkg;

    localparam int DEF_DATA_W   = 4;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_AF_LEVEL = 3;

    localparam logic LANE_0 = 1'b0;
    localparam logic LANE_1 = 1'b1;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);
    localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/demux_fifo_if.sv
// Bundle between the mux-side producer / lane consumers and demux_fifo.
// Almost-full lines exist only when DEMUX_ALMOST_FULL_EN is defined.
interface demux_fifo_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              pop_0;
    logic              pop_1;
    logic [DATA_W-1:0] data_out_0;
    logic [DATA_W-1:0] data_out_1;
    logic              valid_out_0;
    logic              valid_out_1;
    logic              empty_0;
    logic              empty_1;
    logic              full_0;
    logic              full_1;
    logic              overflow;
`ifdef DEMUX_ALMOST_FULL_EN
    logic              almost_full_0;
    logic              almost_full_1;
`endif

    modport master (
        output data_in,
        output valid_in,
        output pop_0,
        output pop_1,
        input  data_out_0,
        input  data_out_1,
        input  valid_out_0,
        input  valid_out_1,
        input  empty_0,
        input  empty_1,
        input  full_0,
        input  full_1,
`ifdef DEMUX_ALMOST_FULL_EN
        input  almost_full_0,
        input  almost_full_1,
`endif
        input  overflow
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  pop_0,
        input  pop_1,
        output data_out_0,
        output data_out_1,
        output valid_out_0,
        output valid_out_1,
        output empty_0,
        output empty_1,
        output full_0,
        output full_1,
`ifdef DEMUX_ALMOST_FULL_EN
        output almost_full_0,
        output almost_full_1,
`endif
        output overflow
    );

endinterface

// File: rtl/demux_fifo_sync_fifo.sv
// One lane buffer: storage, wrap pointers, count, registered read port.
// DEMUX_ALMOST_FULL_EN adds the o_almost_full flag.
module sync_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH
`ifdef DEMUX_ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL = DEF_AF_LEVEL
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_empty,
`ifdef DEMUX_ALMOST_FULL_EN
    output logic              o_almost_full,
`endif
    output logic              o_full
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    logic              w_do_pop;
    logic              w_do_push;
    logic [CNT_W-1:0]  w_count_nxt;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_data  = r_data;
    assign o_valid = r_valid;

`ifdef DEMUX_ALMOST_FULL_EN
    assign o_almost_full = (r_count >= CNT_W'(AF_LEVEL));
`endif

    // A pop on a full lane frees the slot the same-cycle push lands in.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_do_pop;
            if (w_do_pop) begin
                r_data <= r_mem[r_rptr];
            end
        end
    end

endmodule

// File: rtl/demux_fifo.sv
// Splits the mux stream into two lanes by strict alternation, one FIFO each.
// DEMUX_ALMOST_FULL_EN adds almost_full_0/1 on the bus.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH
`ifdef DEMUX_ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL = DEF_AF_LEVEL
`endif
) (
    input  logic         clk,
    input  logic         reset,
    demux_fifo_if.slave  bus
);

    logic r_sel;
    logic r_overflow;

    logic w_push_0;
    logic w_push_1;
    logic w_drop;
    logic w_full_0;
    logic w_full_1;

    assign w_push_0 = bus.valid_in && (r_sel == LANE_0);
    assign w_push_1 = bus.valid_in && (r_sel == LANE_1);

    // Full implies non-empty, so a pop request here is always honoured.
    assign w_drop = (w_push_0 && w_full_0 && !bus.pop_0)
                 || (w_push_1 && w_full_1 && !bus.pop_1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel      <= LANE_0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.valid_in) begin
                r_sel <= ~r_sel;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.overflow = r_overflow;
    assign bus.full_0   = w_full_0;
    assign bus.full_1   = w_full_1;

    sync_fifo #(
        .DATA_W   (DATA_W),
`ifdef DEMUX_ALMOST_FULL_EN
        .AF_LEVEL (AF_LEVEL),
`endif
        .DEPTH    (DEPTH)
    ) u_lane_0 (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push_0),
        .i_pop         (bus.pop_0),
        .i_data        (bus.data_in),
        .o_data        (bus.data_out_0),
        .o_valid       (bus.valid_out_0),
        .o_empty       (bus.empty_0),
`ifdef DEMUX_ALMOST_FULL_EN
        .o_almost_full (bus.almost_full_0),
`endif
        .o_full        (w_full_0)
    );

    sync_fifo #(
        .DATA_W   (DATA_W),
`ifdef DEMUX_ALMOST_FULL_EN
        .AF_LEVEL (AF_LEVEL),
`endif
        .DEPTH    (DEPTH)
    ) u_lane_1 (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push_1),
        .i_pop         (bus.pop_1),
        .i_data        (bus.data_in),
        .o_data        (bus.data_out_1),
        .o_valid       (bus.valid_out_1),
        .o_empty       (bus.empty_1),
`ifdef DEMUX_ALMOST_FULL_EN
        .o_almost_full (bus.almost_full_1),
`endif
        .o_full        (w_full_1)
    );

endmodule

// File: tb/tb_demux_fifo.sv
// Self-checking bench for demux_fifo against a queue-based lane model.
// Also checks almost_full_N when DEMUX_ALMOST_FULL_EN is defined.
module tb_demux_fifo;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    demux_fifo_if #(.DATA_W(4)) bus ();

    demux_fifo #(.DATA_W(4), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    bit         m_sel;
    bit         m_ovf;
    bit         m_v0;
    bit         m_v1;
    logic [3:0] m_d0;
    logic [3:0] m_d1;

    // Lane model: pops see the pre-edge queue, then the push lands.
    task automatic model(bit r, bit v, logic [3:0] d, bit p0, bit p1);
        if (r) begin
            q0.delete();
            q1.delete();
            m_sel = 0;
            m_ovf = 0;
            m_v0  = 0;
            m_v1  = 0;
            m_d0  = 4'h0;
            m_d1  = 4'h0;
            return;
        end
        m_v0 = 0;
        m_v1 = 0;
        if (p0 && q0.size() != 0) begin
            m_d0 = q0.pop_front();
            m_v0 = 1;
        end
        if (p1 && q1.size() != 0) begin
            m_d1 = q1.pop_front();
            m_v1 = 1;
        end
        if (v) begin
            if (!m_sel) begin
                if (q0.size() < DEPTH) q0.push_back(d);
                else m_ovf = 1;
            end else begin
                if (q1.size() < DEPTH) q1.push_back(d);
                else m_ovf = 1;
            end
            m_sel = !m_sel;
        end
    endtask

    task automatic step(bit r, bit v, logic [3:0] d, bit p0, bit p1);
        reset        = r;
        bus.valid_in = v;
        bus.data_in  = d;
        bus.pop_0    = p0;
        bus.pop_1    = p1;
        @(posedge clk);
        model(r, v, d, p0, p1);
        #1;
    endtask

    function automatic logic [14:0] obs();
        return {bus.valid_out_1, bus.data_out_1,
                bus.valid_out_0, bus.data_out_0,
                bus.full_1, bus.full_0,
                bus.empty_1, bus.empty_0, bus.overflow};
    endfunction

    function automatic logic [14:0] expv();
        return {m_v1, m_d1, m_v0, m_d0,
                q1.size() == DEPTH, q0.size() == DEPTH,
                q1.size() == 0, q0.size() == 0, m_ovf};
    endfunction

    task automatic test_reset();
        step(1, 1, 4'hA, 0, 0);
        step(1, 1, 4'hA, 0, 0);
        n_chk++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_model got %h want %h", obs(), expv());
        end
        n_chk++;
        if ({bus.empty_0, bus.empty_1, bus.valid_out_0,
             bus.valid_out_1, bus.overflow} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 11000",
                     {bus.empty_0, bus.empty_1, bus.valid_out_0,
                      bus.valid_out_1, bus.overflow});
        end
        step(0, 1, 4'h7, 0, 0);
        n_chk++;
        if ({bus.empty_0, bus.empty_1} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_sel got %b want 01",
                     {bus.empty_0, bus.empty_1});
        end
    endtask

    task automatic test_split();
        step(1, 0, 4'h0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 4'(i), 0, 0);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL split_push[%0d] got %h want %h", i, obs(), expv());
            end
        end
        for (int k = 0; k < 4; k++) begin
            logic [3:0] want;
            bit lane;
            lane = (k >= 2);
            want = lane ? 4'(2 + 2 * (k - 2)) : 4'(1 + 2 * k);
            step(0, 0, 4'h0, !lane, lane);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL split_pop_model[%0d] got %h want %h", k, obs(), expv());
            end
            n_chk++;
            if (lane ? ({bus.valid_out_1, bus.data_out_1} !== {1'b1, want})
                     : ({bus.valid_out_0, bus.data_out_0} !== {1'b1, want})) begin
                n_fail++;
                $display("FAIL split_pop[%0d] got v0=%b d0=%h v1=%b d1=%h want %h",
                         k, bus.valid_out_0, bus.data_out_0,
                         bus.valid_out_1, bus.data_out_1, want);
            end
        end
        step(0, 0, 4'h0, 0, 0);
        n_chk++;
        if ({bus.valid_out_0, bus.valid_out_1, bus.data_out_1} !== 6'b00_0100) begin
            n_fail++;
            $display("FAIL split_valid_once got %b%b %h want 00 4",
                     bus.valid_out_0, bus.valid_out_1, bus.data_out_1);
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 4'(i), 0, 0);
            n_chk++;
            if (obs() !== expv() || bus.overflow !== (i >= 8)) begin
                n_fail++;
                $display("FAIL ovf_push[%0d] got %h ovf=%b want %h",
                         i, obs(), bus.overflow, expv());
            end
        end
        n_chk++;
        if ({bus.full_0, bus.full_1} !== 2'b11) begin
            n_fail++;
            $display("FAIL ovf_full got %b want 11", {bus.full_0, bus.full_1});
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 4'h0, 1, 1);
            n_chk++;
            if ({bus.data_out_0, bus.data_out_1, bus.overflow} !==
                {4'(2 * k), 4'(2 * k + 1), 1'b1} || obs() !== expv()) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d] got d0=%h d1=%h ovf=%b want %h %h 1",
                         k, bus.data_out_0, bus.data_out_1, bus.overflow,
                         4'(2 * k), 4'(2 * k + 1));
            end
        end
    endtask

    task automatic test_full_pushpop();
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 0, 0);
        step(0, 1, 4'hF, 1, 0);
        n_chk++;
        if ({bus.overflow, bus.full_0, bus.valid_out_0, bus.data_out_0} !==
            {3'b011, 4'h0} || obs() !== expv()) begin
            n_fail++;
            $display("FAIL fullpp got ovf=%b full0=%b v0=%b d0=%h want 0 1 1 0",
                     bus.overflow, bus.full_0, bus.valid_out_0, bus.data_out_0);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 4'h0, 1, 0);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL fullpp_drain[%0d] got %h want %h", k, obs(), expv());
            end
        end
        n_chk++;
        if (bus.data_out_0 !== 4'hF) begin
            n_fail++;
            $display("FAIL fullpp_last got %h want f", bus.data_out_0);
        end
    endtask

    task automatic test_empty();
        step(1, 0, 4'h0, 0, 0);
        step(0, 0, 4'h0, 0, 1);
        n_chk++;
        if ({bus.valid_out_1, bus.data_out_1} !== 5'b0_0000) begin
            n_fail++;
            $display("FAIL empty_pop got v1=%b d1=%h want 0 0",
                     bus.valid_out_1, bus.data_out_1);
        end
        step(0, 1, 4'h3, 0, 0);
        step(0, 1, 4'h5, 0, 1);
        n_chk++;
        if ({bus.valid_out_1, bus.empty_1} !== 2'b00 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL empty_pushpop got v1=%b e1=%b want 0 0",
                     bus.valid_out_1, bus.empty_1);
        end
        step(0, 0, 4'h0, 0, 1);
        n_chk++;
        if ({bus.valid_out_1, bus.data_out_1} !== 5'b1_0101) begin
            n_fail++;
            $display("FAIL empty_read got v1=%b d1=%h want 1 5",
                     bus.valid_out_1, bus.data_out_1);
        end
        step(0, 0, 4'h0, 0, 1);
        n_chk++;
        if ({bus.valid_out_1, bus.data_out_1} !== 5'b0_0101) begin
            n_fail++;
            $display("FAIL empty_hold got v1=%b d1=%h want 0 5",
                     bus.valid_out_1, bus.data_out_1);
        end
    endtask

    task automatic test_wrap_reset();
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            bit p;
            p = (i % 2 == 1);
            step(0, i < 12, 4'($urandom_range(0, 15)), p, p);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL wrap[%0d] got %h want %h", i, obs(), expv());
            end
        end
        for (int i = 0; i < 10; i++) step(0, 1, 4'($urandom_range(0, 15)), 0, 0);
        step(0, 0, 4'h0, 1, 1);
        step(0, 0, 4'h0, 1, 1);
        step(0, 0, 4'h0, 1, 0);
        n_chk++;
        if (obs() !== expv() || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_prereset got %h want %h", obs(), expv());
        end
        step(1, 0, 4'h0, 0, 0);
        n_chk++;
        if ({bus.empty_0, bus.empty_1, bus.overflow} !== 3'b110) begin
            n_fail++;
            $display("FAIL wrap_reset got %b want 110",
                     {bus.empty_0, bus.empty_1, bus.overflow});
        end
        step(0, 1, 4'hC, 0, 0);
        step(0, 0, 4'h0, 1, 0);
        n_chk++;
        if ({bus.valid_out_0, bus.data_out_0, bus.empty_1} !== 6'b1_1100_1) begin
            n_fail++;
            $display("FAIL wrap_after_reset got v0=%b d0=%h e1=%b want 1 c 1",
                     bus.valid_out_0, bus.data_out_0, bus.empty_1);
        end
    endtask

    task automatic test_random();
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random[%0d] got %h want %h", i, obs(), expv());
            end
`ifdef DEMUX_ALMOST_FULL_EN
            n_chk++;
            if ({bus.almost_full_0, bus.almost_full_1} !==
                {q0.size() >= 3, q1.size() >= 3}) begin
                n_fail++;
                $display("FAIL random_af[%0d] got %b%b want %b%b", i,
                         bus.almost_full_0, bus.almost_full_1,
                         q0.size() >= 3, q1.size() >= 3);
            end
`endif
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.pop_0    = 1'b0;
        bus.pop_1    = 1'b0;
        test_reset();
        test_split();
        test_overflow();
        test_full_pushpop();
        test_empty();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
